// File: rtl/led_arb_pkg.sv
// Shared definitions for the status-LED arbiter: pattern codes, FSM states
// and the owner one-hot helper.
package led_arb_pkg;

  localparam int MAX_REQ = 8;

  localparam logic [1:0] PAT_OFF   = 2'b00;
  localparam logic [1:0] PAT_SOLID = 2'b01;
  localparam logic [1:0] PAT_SLOW  = 2'b10;
  localparam logic [1:0] PAT_FAST  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] one_hot(input logic [2:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks, restarted by a
// synchronous clear so the first tick lands exactly TICK_DIV cycles after it.
module led_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Not gated by clr: the FSM derives clr from tick, so gating would form a loop.
  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments and an async active-low
  // reset, so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Shares one status LED between N_REQ requesters with a minimum hold window and
// a dark gap between owners. Define LED_ARB_RR_EN for round-robin arbitration.
module led_pattern_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 100,
  parameter int GAP_TICKS  = 10,
  parameter int SLOW_HALF  = 50,
  parameter int FAST_HALF  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] pat,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               led
);

  localparam int IDX_W    = $clog2(N_REQ);
  localparam int HOLD_W   = $clog2(HOLD_TICKS) + 1;
  localparam int GAP_W    = $clog2(GAP_TICKS) + 1;
  localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int PH_W     = $clog2(MAX_HALF) + 1;

  state_t            state_q, state_d;
  logic              enter, grant, tick, tick_clr;
  logic [IDX_W-1:0]  owner_q, win_idx;
  logic              win_vld;
  logic [1:0]        pat_q;
  logic [HOLD_W-1:0] hold_q;
  logic [GAP_W-1:0]  gap_q;
  logic [PH_W-1:0]   phase_q, phase_max;
  logic              blink_q;
  logic [N_REQ-1:0]  owner_oh;
  logic              others_req, hold_last, gap_last, phase_last, led_d;

`ifdef LED_ARB_RR_EN
  logic [IDX_W-1:0] rr_q, cand;

  // Reverse scan so the candidate nearest the pointer is assigned last and wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_q) + i) % N_REQ);
      if (req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (grant) begin
      rr_q <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
  end
`endif

  assign owner_oh   = N_REQ'(one_hot(3'(owner_q)));
  assign others_req = |(req & ~owner_oh);
  assign hold_last  = (hold_q == HOLD_W'(HOLD_TICKS - 1));
  assign gap_last   = (gap_q == GAP_W'(GAP_TICKS - 1));
  assign phase_max  = (pat_q == PAT_SLOW) ? PH_W'(SLOW_HALF - 1) : PH_W'(FAST_HALF - 1);
  assign phase_last = (phase_q == phase_max);
  assign tick_clr   = enter || (state_q == IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SHOW;
          enter   = 1'b1;
          grant   = 1'b1;
        end
      end
      SHOW: begin
        if (tick && hold_last) begin
          enter = 1'b1;
          if (others_req) begin
            state_d = GAP;
          end else if (req[owner_q]) begin
            grant = 1'b1;  // sole requester is the owner, so win_idx == owner_q
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (tick && gap_last) begin
          enter = 1'b1;
          if (win_vld) begin
            state_d = SHOW;
            grant   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d = 1'b0;
    case (pat_q)
      PAT_OFF:   led_d = 1'b0;
      PAT_SOLID: led_d = 1'b1;
      default:   led_d = blink_q;
    endcase
  end

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Every state entry (SHOW restart included) zeroes the counters and starts
  // the blink phase lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      pat_q   <= PAT_OFF;
      hold_q  <= '0;
      gap_q   <= '0;
      phase_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= win_idx;
        pat_q   <= pat[{win_idx, 1'b0} +: 2];
      end
      if (enter) begin
        hold_q  <= '0;
        gap_q   <= '0;
        phase_q <= '0;
        blink_q <= 1'b1;
      end else if (tick) begin
        if (state_q == SHOW) begin
          hold_q <= hold_q + 1'b1;
          if (phase_last) begin
            phase_q <= '0;
            blink_q <= ~blink_q;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        if (state_q == GAP) begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= '0;
      busy <= 1'b0;
      led  <= 1'b0;
    end else begin
      gnt  <= (state_q == SHOW) ? owner_oh : '0;
      busy <= (state_q != IDLE);
      led  <= (state_q == SHOW) && led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed bench for led_pattern_arbiter: expected gnt/led/busy per cycle are
// queued with the stimulus and compared on the falling edge.
module tb_led_pattern_arbiter;

  localparam int N_REQ      = 4;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 8;
  localparam int GAP_TICKS  = 2;
  localparam int SLOW_HALF  = 2;
  localparam int FAST_HALF  = 1;

`ifdef LED_ARB_RR_EN
  localparam int         SEC_OWNER = 1;
  localparam logic [1:0] SEC_PAT   = 2'b11;
`else
  localparam int         SEC_OWNER = 0;
  localparam logic [1:0] SEC_PAT   = 2'b01;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic       led;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] pat;
  logic [3:0] gnt;
  logic       busy;
  logic       led;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_pattern_arbiter #(
    .N_REQ     (N_REQ),
    .TICK_DIV  (TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .SLOW_HALF (SLOW_HALF),
    .FAST_HALF (FAST_HALF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .pat  (pat),
    .gnt  (gnt),
    .busy (busy),
    .led  (led)
  );

  task automatic push(input int n, input logic [3:0] g, input logic l, input logic b,
                      input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.gnt  = g;
      e.led  = l;
      e.busy = b;
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  // Expected SHOW window of n cycles starting right after a (re)entry.
  task automatic push_show(input int n, input int owner, input logic [1:0] p,
                           input string tag);
    int   half_cyc;
    logic l;
    half_cyc = ((p == 2'b10) ? SLOW_HALF : FAST_HALF) * TICK_DIV;
    for (int i = 0; i < n; i++) begin
      case (p)
        2'b00:   l = 1'b0;
        2'b01:   l = 1'b1;
        default: l = ((i / half_cyc) % 2) == 0;
      endcase
      push(1, 4'(1 << owner), l, 1'b1, tag);
    end
  endtask

  task automatic compare(input exp_t e);
    n_tests++;
    assert ({gnt, led, busy} === {e.gnt, e.led, e.busy})
    else begin
      n_fail++;
      $error("FAIL %s: gnt=%b led=%b busy=%b, expected gnt=%b led=%b busy=%b",
             e.tag, gnt, led, busy, e.gnt, e.led, e.busy);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      compare(sb.pop_front());
    end
  endtask

  task automatic check_now();
    compare(sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    pat   = 8'h00;
    #2;
    push(1, 4'b0000, 1'b0, 1'b0, "reset");
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    push(2, 4'b0000, 1'b0, 1'b0, "idle");
    drain();

    // Two requesters: owner, gap, next owner, repeatedly.
    req = 4'b0011;
    pat = 8'b0000_1101;
    push(1, 4'b0000, 1'b0, 1'b0, "arb_latency");
    push_show(32, 0, 2'b01, "arb_owner1");
    push(8, 4'b0000, 1'b0, 1'b1, "arb_gap1");
    push_show(32, SEC_OWNER, SEC_PAT, "arb_owner2");
    push(8, 4'b0000, 1'b0, 1'b1, "arb_gap2");
    push_show(32, 0, 2'b01, "arb_owner3");
    push(8, 4'b0000, 1'b0, 1'b1, "arb_gap3");
    drain();
    req = 4'b0000;
    push_show(32, SEC_OWNER, SEC_PAT, "arb_owner4");
    push(2, 4'b0000, 1'b0, 1'b0, "arb_idle");
    drain();

    // Single requester: solid, pattern latched only at grant/restart, blink rates.
    req = 4'b0001;
    pat = 8'b0000_0001;
    push(1, 4'b0000, 1'b0, 1'b0, "solid_latency");
    push(10, 4'b0001, 1'b1, 1'b1, "solid");
    drain();
    pat = 8'b0000_0000;
    push(22, 4'b0001, 1'b1, 1'b1, "pat_ignored");
    push(5, 4'b0001, 1'b0, 1'b1, "restart_relatch");
    drain();
    pat = 8'b0000_0010;
    push(27, 4'b0001, 1'b0, 1'b1, "off_hold");
    push_show(32, 0, 2'b10, "slow_blink");
    drain();
    pat = 8'b0000_0011;
    push_show(32, 0, 2'b10, "slow_blink2");
    push_show(16, 0, 2'b11, "fast_blink");
    drain();
    req = 4'b0000;
    push_show(16, 0, 2'b11, "fast_tail");
    push(2, 4'b0000, 1'b0, 1'b0, "solo_idle");
    drain();

    // Owner drops its request early: still shown for the full hold window.
    req = 4'b0001;
    pat = 8'b0000_0001;
    push(1, 4'b0000, 1'b0, 1'b0, "drop_latency");
    push(5, 4'b0001, 1'b1, 1'b1, "drop_before");
    drain();
    req = 4'b0000;
    push(27, 4'b0001, 1'b1, 1'b1, "drop_hold");
    push(3, 4'b0000, 1'b0, 1'b0, "drop_idle");
    drain();

    // Asynchronous reset in the middle of SHOW, then a fresh grant.
    req = 4'b0010;
    pat = 8'b0000_1000;
    push(1, 4'b0000, 1'b0, 1'b0, "pre_rst_latency");
    push_show(10, 1, 2'b10, "pre_rst_show");
    drain();
    rst_n = 1'b0;
    #1;
    push(1, 4'b0000, 1'b0, 1'b0, "rst_async");
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 4'b0000, 1'b0, 1'b0, "rst_latency");
    push_show(16, 1, 2'b10, "rst_regrant");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
